mem_access_stage: RTL and testbench

- MEM stage of the 5-stage pipeline; consumes the execute-stage result bundle (ALU result, destination register, load/store address field, opcode).
- ALU results pass through to writeback.
- Loads and stores run a req/ack transaction on the data-memory port.
- Stalls upstream while a memory transaction is outstanding, then presents a single writeback bundle.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/mem_access_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline: opcode map, MEM-stage FSM
//   encoding and default datapath widths.
// Latency: n/a (declarations only).  Backpressure: n/a.
package pipe_pkg;

  // Default datapath widths; stages take these as parameter defaults.
  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;
  localparam int ADDR_W_DEF = 8;

  // Opcode map.  Anything not listed here is treated as an ALU op that
  // writes its result back.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_SW  = 4'b0100;
  localparam logic [3:0] OP_BEQ = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;

  // MEM-stage FSM: IDLE accepts bundles, ACCESS owns the data-memory port.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  // True for opcodes that need a data-memory transaction.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Branches retire without touching the register file.
  function automatic logic is_branch_op(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/mem_access_stage.sv
// MEM stage: ALU/branch results retire one cycle after acceptance; lw/sw run a
//   req/ack transaction on the data-memory port and retire the cycle after ack.
// Latency: 1 cycle for ALU/branch, >= 2 cycles for lw/sw (ack-dependent).
// Backpressure: registered stall is high for every ACCESS cycle; inputs are
//   ignored while stalled.
//
// Ports:
//   clkwire, rstwire            clock, synchronous active-high reset
//   valid_in, alu_in, regdest_in, ldst_in, instruction_in
//                               execute-stage bundle (taken when valid_in && !stall)
//   stall                       upstream must hold its bundle
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack
//                               data-memory port; request held stable until ack
//   wb_valid, wb_en, wb_regdest, wb_data
//                               writeback bundle; wb_valid is a one-cycle pulse
//   mem_err                     sticky ack-timeout flag
//
// Build option: define MEM_TIMEOUT_EN to abandon an access after TIMEOUT_CYC
// un-acked ACCESS cycles (retires with wb_en = 0 and sets mem_err). Without it
// ACCESS waits for ack indefinitely and mem_err is tied 0.
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clkwire,
  input  logic              rstwire,

  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [REG_W-1:0]  regdest_in,
  input  logic [REG_W-1:0]  ldst_in,
  input  logic [3:0]        instruction_in,
  output logic              stall,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,

  output logic              wb_valid,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_regdest,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  // Elaboration-time sanity on the configuration.
  if (ADDR_W < REG_W) begin : g_bad_addr_w
    $error("mem_access_stage: ADDR_W must be >= REG_W (ldst field is zero-extended)");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_access_stage: TIMEOUT_CYC must be at least 1");
  end

  mem_state_t       state;
  logic [REG_W-1:0] lat_regdest;  // destination of the in-flight lw/sw
  logic             lat_is_lw;    // in-flight access is a load

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  // The access times out on the edge where the count would reach TIMEOUT_CYC,
  // so mem_req is high for exactly TIMEOUT_CYC cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             mem_err_q;

  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clkwire) begin
    if (rstwire) begin
      // Any in-flight access is abandoned; memory sees mem_req drop next cycle.
      state       <= ST_IDLE;
      stall       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_en       <= 1'b0;
      wb_regdest  <= '0;
      wb_data     <= '0;
      lat_regdest <= '0;
      lat_is_lw   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt     <= '0;
      mem_err_q   <= 1'b0;
`endif
    end else begin
      // wb_valid/wb_en are single-cycle pulses; the data/regdest fields keep
      // their last value between retirements.
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (valid_in) begin
            if (is_mem_op(instruction_in)) begin
              state       <= ST_ACCESS;
              stall       <= 1'b1;
              mem_req     <= 1'b1;
              mem_we      <= (instruction_in == OP_SW);
              mem_addr    <= ADDR_W'(ldst_in);
              mem_wdata   <= alu_in;
              lat_regdest <= regdest_in;
              lat_is_lw   <= (instruction_in == OP_LW);
`ifdef MEM_TIMEOUT_EN
              tmo_cnt     <= '0;
`endif
            end else begin
              wb_valid   <= 1'b1;
              wb_en      <= !is_branch_op(instruction_in);
              wb_regdest <= regdest_in;
              wb_data    <= alu_in;
            end
          end
        end

        ST_ACCESS: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (mem_ack) begin
            state      <= ST_IDLE;
            stall      <= 1'b0;
            mem_req    <= 1'b0;
            wb_valid   <= 1'b1;
            wb_en      <= lat_is_lw;
            wb_regdest <= lat_regdest;
            wb_data    <= lat_is_lw ? mem_rdata : mem_wdata;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state      <= ST_IDLE;
            stall      <= 1'b0;
            mem_req    <= 1'b0;
            wb_valid   <= 1'b1;
            wb_en      <= 1'b0;
            wb_regdest <= lat_regdest;
            mem_err_q  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end

        default: begin
          state   <= ST_IDLE;
          stall   <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage. Inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_mem_access_stage;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int ADDR_W = 8;
  localparam int TMO    = 4;

  localparam logic [3:0] C_ADD = 4'b0000;
  localparam logic [3:0] C_LW  = 4'b0011;
  localparam logic [3:0] C_SW  = 4'b0100;
  localparam logic [3:0] C_BNE = 4'b0110;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [DATA_W-1:0] alu_in;
  logic [REG_W-1:0]  regdest_in;
  logic [REG_W-1:0]  ldst_in;
  logic [3:0]        instruction_in;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              wb_valid;
  logic              wb_en;
  logic [REG_W-1:0]  wb_regdest;
  logic [DATA_W-1:0] wb_data;
  logic              mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clkwire(clk), .rstwire(rst),
    .valid_in(valid_in), .alu_in(alu_in), .regdest_in(regdest_in),
    .ldst_in(ldst_in), .instruction_in(instruction_in), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_regdest(wb_regdest),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu,
                       input logic [3:0] rd, input logic [3:0] ld);
    valid_in = v; instruction_in = op; alu_in = alu; regdest_in = rd; ldst_in = ld;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive(1'b0, C_ADD, 16'h0, 4'h0, 4'h0);
    tick(); tick();
    checks++;
    if ({stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_en, wb_regdest, wb_data, mem_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b req=%b we=%b addr=%h wdata=%h wbv=%b wben=%b rd=%h data=%h err=%b, all required 0",
               stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_en, wb_regdest, wb_data, mem_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    drive(1'b1, C_ADD, 16'h0012, 4'd3, 4'd0);
    tick();
    drive(1'b0, C_ADD, 16'h0, 4'd0, 4'd0);
    checks++;
    if ({wb_valid, wb_en, wb_regdest, wb_data, stall} !== {1'b1, 1'b1, 4'd3, 16'h0012, 1'b0}) begin
      errors++;
      $display("FAIL alu_retire: wbv=%b wben=%b rd=%0d data=%h stall=%b, required 1 1 3 0012 0",
               wb_valid, wb_en, wb_regdest, wb_data, stall);
    end
    tick();
    checks++;
    if ({wb_valid, wb_en, wb_data} !== {1'b0, 1'b0, 16'h0012}) begin
      errors++;
      $display("FAIL alu_pulse_end: wbv=%b wben=%b data=%h, required 0 0 0012 (data retained)",
               wb_valid, wb_en, wb_data);
    end
  endtask

  task automatic test_lw();
    drive(1'b1, C_LW, 16'h1111, 4'd2, 4'd5);
    tick();
    for (int i = 0; i < 3; i++) begin
      // Junk add presented while stalled must be ignored.
      drive(1'b1, C_ADD, 16'h7777, 4'd9, 4'd1);
      checks++;
      if ({mem_req, mem_we, mem_addr, stall, wb_valid} !== {1'b1, 1'b0, 8'h05, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL lw_access cyc%0d: req=%b we=%b addr=%h stall=%b wbv=%b, required 1 0 05 1 0",
                 i, mem_req, mem_we, mem_addr, stall, wb_valid);
      end
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      tick();
    end
    drive(1'b0, C_ADD, 16'h0, 4'd0, 4'd0);
    mem_ack = 1'b0; mem_rdata = 16'h0;
    checks++;
    if ({mem_req, stall, wb_valid, wb_en, wb_regdest, wb_data} !== {1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 16'hBEEF}) begin
      errors++;
      $display("FAIL lw_retire: req=%b stall=%b wbv=%b wben=%b rd=%0d data=%h, required 0 0 1 1 2 beef",
               mem_req, stall, wb_valid, wb_en, wb_regdest, wb_data);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_no_junk_retire: wbv=%b, required 0", wb_valid);
    end
  endtask

  task automatic test_sw();
    drive(1'b1, C_SW, 16'h00AA, 4'd9, 4'd7);
    tick();
    drive(1'b0, C_ADD, 16'h0, 4'd0, 4'd0);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, stall} !== {1'b1, 1'b1, 8'h07, 16'h00AA, 1'b1}) begin
      errors++;
      $display("FAIL sw_access: req=%b we=%b addr=%h wdata=%h stall=%b, required 1 1 07 00aa 1",
               mem_req, mem_we, mem_addr, mem_wdata, stall);
    end
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, wb_valid, wb_en, wb_regdest, wb_data} !== {1'b0, 1'b1, 1'b0, 4'd9, 16'h00AA}) begin
      errors++;
      $display("FAIL sw_retire: req=%b wbv=%b wben=%b rd=%0d data=%h, required 0 1 0 9 00aa",
               mem_req, wb_valid, wb_en, wb_regdest, wb_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, C_BNE, 16'h0055, 4'd4, 4'd0);
    tick();
    checks++;
    if ({wb_valid, wb_en, wb_regdest, wb_data} !== {1'b1, 1'b0, 4'd4, 16'h0055}) begin
      errors++;
      $display("FAIL b2b_bne: wbv=%b wben=%b rd=%0d data=%h, required 1 0 4 0055",
               wb_valid, wb_en, wb_regdest, wb_data);
    end
    drive(1'b1, C_ADD, 16'h0066, 4'd6, 4'd0);
    tick();
    drive(1'b0, C_ADD, 16'h0, 4'd0, 4'd0);
    checks++;
    if ({wb_valid, wb_en, wb_regdest, wb_data} !== {1'b1, 1'b1, 4'd6, 16'h0066}) begin
      errors++;
      $display("FAIL b2b_add: wbv=%b wben=%b rd=%0d data=%h, required 1 1 6 0066",
               wb_valid, wb_en, wb_regdest, wb_data);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: wbv=%b, required 0", wb_valid);
    end
  endtask

  task automatic test_ack_held();
    // Ack high while idle is ignored.
    mem_ack = 1'b1; mem_rdata = 16'hC0DE;
    tick();
    checks++;
    if ({wb_valid, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL ack_idle: wbv=%b req=%b, required 0 0", wb_valid, mem_req);
    end
    // lw accepted with ack already high: one ACCESS cycle, one retire.
    drive(1'b1, C_LW, 16'h0, 4'd8, 4'd3);
    tick();
    drive(1'b0, C_ADD, 16'h0, 4'd0, 4'd0);
    checks++;
    if ({mem_req, mem_addr, wb_valid} !== {1'b1, 8'h03, 1'b0}) begin
      errors++;
      $display("FAIL ack_held_access: req=%b addr=%h wbv=%b, required 1 03 0", mem_req, mem_addr, wb_valid);
    end
    tick();
    checks++;
    if ({wb_valid, wb_en, wb_regdest, wb_data} !== {1'b1, 1'b1, 4'd8, 16'hC0DE}) begin
      errors++;
      $display("FAIL ack_held_retire: wbv=%b wben=%b rd=%0d data=%h, required 1 1 8 c0de",
               wb_valid, wb_en, wb_regdest, wb_data);
    end
    tick();
    checks++;
    if ({wb_valid, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL ack_held_once: wbv=%b req=%b, required 0 0", wb_valid, mem_req);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_in_access();
    drive(1'b1, C_LW, 16'h0, 4'd1, 4'd2);
    tick();
    drive(1'b0, C_ADD, 16'h0, 4'd0, 4'd0);
    checks++;
    if ({mem_req, stall} !== 2'b11) begin
      errors++;
      $display("FAIL rst_access_pre: req=%b stall=%b, required 1 1", mem_req, stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({mem_req, stall, wb_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_access_abort: req=%b stall=%b wbv=%b, required 0 0 0", mem_req, stall, wb_valid);
    end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, wb_valid, wb_data} !== {1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL rst_late_ack: req=%b wbv=%b data=%h, required 0 0 0000", mem_req, wb_valid, wb_data);
    end
  endtask

  task automatic test_timeout();
    drive(1'b1, C_LW, 16'h0, 4'd5, 4'd6);
    tick();
    drive(1'b0, C_ADD, 16'h0, 4'd0, 4'd0);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      checks++;
      if ({mem_req, stall, mem_err} !== 3'b110) begin
        errors++;
        $display("FAIL tmo_wait cyc%0d: req=%b stall=%b err=%b, required 1 1 0", i, mem_req, stall, mem_err);
      end
      tick();
    end
    checks++;
    if ({mem_req, stall, mem_err, wb_valid, wb_en, wb_regdest} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5}) begin
      errors++;
      $display("FAIL tmo_expire: req=%b stall=%b err=%b wbv=%b wben=%b rd=%0d, required 0 0 1 1 0 5",
               mem_req, stall, mem_err, wb_valid, wb_en, wb_regdest);
    end
    tick();
    checks++;
    if ({mem_err, wb_valid} !== 2'b10) begin
      errors++;
      $display("FAIL tmo_sticky: err=%b wbv=%b, required 1 0", mem_err, wb_valid);
    end
`else
    // Without the timeout the access waits indefinitely.
    for (int i = 0; i < 3 * TMO; i++) tick();
    checks++;
    if ({mem_req, stall, wb_valid, mem_err} !== 4'b1100) begin
      errors++;
      $display("FAIL no_tmo_wait: req=%b stall=%b wbv=%b err=%b, required 1 1 0 0",
               mem_req, stall, wb_valid, mem_err);
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({mem_req, mem_err, stall} !== 3'b000) begin
      errors++;
      $display("FAIL tmo_reset_clear: req=%b err=%b stall=%b, required 0 0 0", mem_req, mem_err, stall);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_sw();
    test_back_to_back();
    test_ack_held();
    test_reset_in_access();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
